// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the instruction memory port; streams a program in (LOAD) and fetches it out to decode (RUN)
module imem_fetch_ctrl #(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load_start,
    input  logic        i_load_valid,
    input  logic [31:0] i_load_data,
    input  logic        i_load_last,
    output logic        o_load_ready,
    output logic        o_load_done,
    output logic        o_load_overflow,
    input  logic        i_run_start,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_we,
    output logic [31:0] o_imem_wdata,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_halt,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic        o_misalign,
    output logic [1:0]  o_state
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] PC_MASK = 32'(4 * DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t          r_state, w_next;
    logic [AW-1:0]   r_load_cnt;
    logic [31:0]     r_pc;
    logic [31:0]     r_instr, r_instr_pc;
    logic            r_instr_valid, r_load_done, r_load_overflow, r_misalign;

    logic w_accept, w_cnt_full, w_load_end, w_redirect, w_free, w_fetch, w_start_load, w_start_run;

    assign w_accept     = (r_state == S_LOAD) && i_load_valid;
    assign w_cnt_full   = r_load_cnt == AW'(DEPTH - 1);
    assign w_load_end   = w_accept && (i_load_last || w_cnt_full);
    assign w_redirect   = (r_state == S_RUN) && i_branch_taken;
    assign w_free       = !r_instr_valid || i_instr_ready;
    assign w_fetch      = (r_state == S_RUN) && !i_branch_taken && !i_halt && w_free;
    assign w_start_load = ((r_state == S_IDLE) || (r_state == S_HALT)) && i_load_start;
    assign w_start_run  = (r_state == S_IDLE) && !i_load_start && i_run_start;

    assign o_load_ready    = r_state == S_LOAD;
    assign o_imem_we       = w_accept;
    assign o_imem_wdata    = i_load_data;
    assign o_imem_addr     = (r_state == S_LOAD) ? 32'(r_load_cnt) :
                             (r_state == S_IDLE) ? 32'h0 : r_pc;
    assign o_load_done     = r_load_done;
    assign o_load_overflow = r_load_overflow;
    assign o_instr         = r_instr;
    assign o_instr_pc      = r_instr_pc;
    assign o_instr_valid   = r_instr_valid;
    assign o_misalign      = r_misalign;
    assign o_state         = r_state;

    // state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // next-state: load_start beats run_start; halt in RUN is taken even alongside a redirect
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_load_start ? S_LOAD : i_run_start ? S_RUN : S_IDLE;
            S_LOAD:  w_next = w_load_end ? S_IDLE : S_LOAD;
            S_RUN:   w_next = i_halt ? S_HALT : S_RUN;
            S_HALT:  w_next = i_load_start ? S_LOAD : S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // load counter, pc and the registered decode output stage
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_load_cnt      <= '0;
            r_pc            <= RESET_PC;
            r_instr         <= '0;
            r_instr_pc      <= '0;
            r_instr_valid   <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_overflow <= 1'b0;
            r_misalign      <= 1'b0;
        end else begin
            r_load_done <= w_load_end;
            r_misalign  <= w_redirect && (i_branch_target[1:0] != 2'b00);
            if (w_start_load) begin
                r_load_cnt      <= '0;
                r_load_overflow <= 1'b0;
            end else if (w_accept) begin
                r_load_cnt <= r_load_cnt + AW'(1);
                if (!i_load_last && w_cnt_full) r_load_overflow <= 1'b1;
            end
            if (w_start_run)     r_pc <= RESET_PC;
            else if (w_redirect) r_pc <= {i_branch_target[31:2], 2'b00} & PC_MASK;
            else if (w_fetch)    r_pc <= (r_pc + 32'd4) & PC_MASK;
            if (w_fetch) begin
                r_instr       <= i_imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end else if (w_redirect || (r_instr_valid && i_instr_ready)) begin
                r_instr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequencer that owns the instruction memory's single address/write port.
- LOAD mode streams a program into memory through a valid/ready word stream.
- RUN mode drives a PC, reads instructions and presents them to decode through a registered valid/ready output stage, with branch redirect and halt.
- Sits between the boot/test loader, the instruction memory and the CPU decode stage.

Parameters:
DEPTH, 1024, memory depth in 32-bit words; must be a power of two.
RESET_PC, 0, byte address loaded into the PC on reset and on run_start.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
load_start  input  1  pulse; in IDLE or HALT, enter LOAD.
load_valid  input  1  load word valid.
load_data  input  32  load word.
load_last  input  1  marks final load word; qualified by load_valid.
load_ready  output  1  controller accepts a load word this cycle.
load_done  output  1  one-cycle pulse after the load completes.
load_overflow  output  1  sticky; memory filled without load_last.
run_start  input  1  pulse; in IDLE, enter RUN at RESET_PC.
imem_addr  output  32  memory address: word index in LOAD, byte PC in RUN.
imem_we  output  1  memory write enable.
imem_wdata  output  32  memory write data.
imem_rdata  input  32  memory read data; combinational from imem_addr.
branch_taken  input  1  redirect request.
branch_target  input  32  redirect byte address.
halt  input  1  stop fetching.
instr  output  32  fetched instruction.
instr_pc  output  32  byte address of instr.
instr_valid  output  1  instr/instr_pc valid.
instr_ready  input  1  decode accepts instr.
misalign  output  1  one-cycle pulse; branch_target[1:0] was nonzero.
state  output  2  IDLE=0, LOAD=1, RUN=2, HALT=3.

Behaviour:
Reset (async, any state, including mid-load):
- state=IDLE, pc=RESET_PC, load_cnt=0.
- instr=0, instr_pc=0, instr_valid=0.
- load_done=0, load_overflow=0, misalign=0.
- Memory contents are untouched.

Combinational outputs:
- imem_we = (state==LOAD) & load_valid. imem_wdata = load_data.
- imem_addr = load_cnt in LOAD, pc in RUN/HALT, 0 in IDLE.
- load_ready = (state==LOAD).

IDLE:
- load_start goes to LOAD; it clears load_cnt and load_overflow.
- Otherwise run_start goes to RUN and sets pc=RESET_PC.
- If both are asserted in the same cycle, load_start wins.

LOAD:
- Each accepted word is written in the same cycle at word index load_cnt, then load_cnt increments.
- Accepted with load_last=1: go to IDLE; load_done pulses on the following cycle.
- Accepted at load_cnt==DEPTH-1 with load_last=0: go to IDLE, set load_overflow, pulse load_done.
- Other inputs (run_start, branch_taken, halt) are ignored.

RUN:
- The output stage is free when instr_valid==0, or when instr_valid & instr_ready.
- When free (and no redirect): instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=(pc+4) mod 4*DEPTH.
- When not free: pc and the output stage hold (stall).
- Back-to-back throughput is 1 instruction/cycle while instr_ready=1. Latency from PC to instr_valid is 1 cycle.

Redirect (RUN only):
- branch_taken has priority over fetch.
- pc <= {branch_target[31:2],2'b00} mod 4*DEPTH; instr_valid<=0 (flush). No fetch occurs that cycle.
- misalign pulses if branch_target[1:0]!=0.

Halt:
- halt in RUN (no branch_taken): go to HALT, with no further fetch.
- A currently valid instr stays until it is accepted; it is then cleared.
- If branch_taken and halt are asserted together: the redirect is applied, and the state still goes to HALT.

HALT:
- pc is frozen.
- load_start goes to LOAD. run_start is ignored.
- Otherwise the state stays in HALT until reset.

PC wrap: pc at 4*DEPTH-4 advances to 0.

Test Plan:
- Load 3 words 0x11,0x22,0x33, last on the third, with load_valid held 1 -> imem_we high for 3 cycles at addr 0,1,2; load_done pulses 1 cycle after; state=IDLE; load_overflow=0.
- run_start after that load, instr_ready=1 -> instr_valid from the 2nd cycle; instr_pc = 0,4,8 on consecutive cycles; instr = mem[0..2].
- instr_ready=0 for 3 cycles mid-run -> instr and instr_pc held, pc unchanged; fetch resumes at the next pc when ready returns; no skips or duplicates.
- branch_taken with target 0x0000_0102 -> instr_valid=0 next cycle; misalign pulses; next instr_pc=0x100.
- DEPTH=4 bench: load 4 words without load_last -> load_overflow=1, load_done pulses; in RUN, pc wraps 0xC -> 0x0.
- reset asserted mid-LOAD after 2 words -> immediate IDLE, all outputs 0; the 2 written words remain in memory.
